// File: rtl/sam_ifetch.sv
// Instruction fetch unit: owns the word-addressed fetch PC, issues ready/valid
// requests to instruction memory and buffers in-order responses for decode.
module sam_ifetch #(
  parameter int          QDEPTH   = 2,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        RN,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        br_en,
  input  logic [31:0] br_target,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] IF_ID_IR,
  output logic [31:0] IF_ID_NPC
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int SW = CW + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   deq_pc;
  logic [31:0]   queue [QDEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;

  logic          deq;
  logic          resp;
  logic          push;
  logic          accepted;
  logic [SW-1:0] credits_used;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // NOTE: every signal assigned in this block gets a value on every path, so no latch is inferred.
  always_comb begin
    deq          = if_valid & id_ready & ~br_en;
    resp         = imem_rvalid & (outstanding != '0);
    push         = resp & ~br_en & (drop_cnt == '0);
    credits_used = SW'(count) + SW'(outstanding) - SW'(deq);
    // RN gates the request so nothing is issued while the block is held in reset.
    imem_req     = RN & ~br_en & (credits_used < SW'(QDEPTH));
    accepted     = imem_req & imem_ready;
  end

  assign imem_addr = fetch_pc;
  assign if_valid  = (count != '0);
  assign IF_ID_IR  = if_valid ? queue[rd_ptr] : 32'h0;
  assign IF_ID_NPC = deq_pc + 32'd1;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      fetch_pc    <= RESET_PC;
      deq_pc      <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (br_en) begin
      // Every request still in flight, minus the one answering now, is stale.
      fetch_pc    <= br_target;
      deq_pc      <= br_target;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= outstanding - CW'(resp);
      drop_cnt    <= outstanding - CW'(resp);
    end else begin
      if (accepted) fetch_pc <= fetch_pc + 32'd1;
      outstanding <= outstanding + CW'(accepted) - CW'(resp);
      if (resp && (drop_cnt != '0)) drop_cnt <= drop_cnt - CW'(1);
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (deq) begin
        rd_ptr <= next_ptr(rd_ptr);
        deq_pc <= deq_pc + 32'd1;
      end
      count <= count + CW'(push) - CW'(deq);
    end
  end

  // NOTE: queue storage is not reset; count gates every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push) queue[wr_ptr] <= imem_rdata;
  end

endmodule

// File: doc/sam_ifetch.md
# sam_ifetch

Instruction fetch unit for the sam_rv32i pipeline. Sits directly upstream of the decode stage and owns the word-addressed fetch PC. Issues requests to instruction memory over a ready/valid interface and buffers returned words in a small in-order prefetch queue. Presents one instruction per cycle with its next-PC (`IF_ID_IR`, `IF_ID_NPC`) and flushes everything on a branch redirect from execute.

## Interface

**Parameters**
- `QDEPTH`, default 2: maximum instruction words buffered plus outstanding (credit limit); range 2–8.
- `RESET_PC`, default 32'd0: word address fetched first after reset.

**Ports**
- `clk` — in, 1: sole clock, rising edge.
- `RN` — in, 1: asynchronous, active-low reset.
- `imem_req` — out, 1: fetch request valid.
- `imem_addr` — out, 32: word address of request; equals `fetch_pc`.
- `imem_ready` — in, 1: memory accepts the request this cycle.
- `imem_rvalid` — in, 1: response word valid; responses return in request order.
- `imem_rdata` — in, 32: instruction word.
- `br_en` — in, 1: redirect request from execute, one-cycle pulse.
- `br_target` — in, 32: redirect word address, sampled when `br_en` is high.
- `id_ready` — in, 1: decode accepts the head instruction.
- `if_valid` — out, 1: `IF_ID_IR`/`IF_ID_NPC` hold a real instruction.
- `IF_ID_IR` — out, 32: head instruction; 32'h0 when `if_valid` is 0.
- `IF_ID_NPC` — out, 32: `deq_pc + 1`, the word address after the head instruction.

## Operation

**State**
- `fetch_pc`: next address to request.
- `deq_pc`: address of the queue head.
- Queue: `QDEPTH` entries with read/write pointers and `count`.
- `outstanding`: number of accepted requests not yet answered.
- `drop_cnt`: number of pending responses to discard.

**Handshakes**
- `deq = if_valid & id_ready & ~br_en`.
- `imem_req = ~br_en & (count + outstanding - deq < QDEPTH)`. Combinational; must not depend on `imem_ready`.
- A request is accepted when `imem_req & imem_ready`. On acceptance: `fetch_pc <= fetch_pc + 1` (32-bit wrap, 32'hFFFFFFFF → 0) and `outstanding` increments.
- Response (`imem_rvalid`):
  - Always decrements `outstanding`.
  - If `drop_cnt > 0`: word is discarded and `drop_cnt` decrements.
  - Otherwise: word is pushed at the queue tail.
  - `imem_rvalid` with `outstanding == 0` is a protocol violation; the block ignores it and leaves all state unchanged.
- Dequeue: advances the read pointer and sets `deq_pc <= deq_pc + 1` (wraps).
- Push and pop in the same cycle is legal, including when the queue is full.

**Redirect (`br_en = 1`)**, all at the same edge:
- Queue emptied (`count <= 0`); the head is not consumed.
- `fetch_pc <= br_target` and `deq_pc <= br_target`.
- `drop_cnt <= outstanding + (accepted ? 1 : 0) - (imem_rvalid ? 1 : 0)`. `accepted` is always 0, since `imem_req` is low during a redirect.
- A response arriving in the same cycle is discarded.
- Back-to-back redirects: the last one wins; drop accounting stays cumulative.

**Reset (`RN` low, asynchronous)**
- `fetch_pc = deq_pc = RESET_PC`.
- `count`, `outstanding` and `drop_cnt` are 0.
- Outputs: `if_valid` 0, `IF_ID_IR` 32'h0, `IF_ID_NPC` `RESET_PC + 1`, `imem_req` 0 while `RN` is low, `imem_addr` `RESET_PC`.
- In-flight memory responses are forgotten. The memory is reset by the same `RN`, so no stale responses return after reset.

## Timing

- Request accepted at edge t → `imem_rvalid` is no earlier than the cycle after t. The word is enqueued at that edge, and `if_valid` rises in the following cycle (fall-through is not allowed).
- With single-cycle memory and `imem_ready` tied high:
  - First request goes out in the first cycle after `RN` deasserts.
  - First `if_valid` appears 2 edges later.
  - Sustained throughput is 1 instruction/cycle with `QDEPTH=2`.
- Redirect at edge t: `imem_req` for `br_target` is asserted in cycle t+1. With single-cycle memory, the target instruction is valid at cycle t+3.
- `IF_ID_IR` and `IF_ID_NPC` must stay stable while `if_valid & ~id_ready`.
- Redirect-to-output latency does not depend on how many responses are being dropped, as long as the memory keeps answering.

## Test plan

1. **Stream:** `RESET_PC=10`, 1-cycle memory with `MEM[a]=a`, `id_ready=1`. Expect `IF_ID_IR` 10,11,12… with `IF_ID_NPC` 11,12,13…, `if_valid` continuous from the 3rd edge after reset.
2. **Backpressure:** drop `id_ready` for 5 cycles mid-stream. Expect `imem_req` low once `count + outstanding = QDEPTH`, head held stable, no words lost or duplicated when `id_ready` returns.
3. **Redirect with 2-cycle memory:** pulse `br_en` with `br_target=20` while 2 requests are outstanding. Expect both stale responses dropped and the next valid output to be IR=20, NPC=21.
4. **Simultaneous redirect and response:** `br_en` in the same cycle as `imem_rvalid`. Expect that word discarded, `drop_cnt` correct, and no stray instruction before 20.
5. **Stall and wrap:** `imem_ready=0` for 4 cycles. Expect `imem_req` held with `imem_addr` constant. Then redirect to 32'hFFFFFFFF: expect outputs FFFFFFFF then 0, with NPC 0 then 1.
6. **Reset mid-operation:** assert `RN` low asynchronously mid-stream. Expect outputs to reach reset values immediately without waiting for a clock edge, and fetch to restart at `RESET_PC`.
